// File: rtl/fp_div_iter_param.sv
// Iterative restoring floating-point divider, round-to-nearest-even, one quotient bit per cycle.
// Define FP_DIV_FLAGS_EN to build the exception flags; otherwise flags reads 5'b0.
//
// state    | meaning
// S_IDLE   | ready, waiting for valid_in
// S_UNPACK | decode operands, resolve special cases, seed the divider
// S_DIV    | one trial subtraction per cycle
// S_ROUND  | round, range-check, publish result
module fp_div_iter_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 ready,
    output logic                 valid_out,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int QW    = MAN_W + 3;
    localparam int XW    = EXP_W + 2;
    localparam int CW    = $clog2(QW);
    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_DIV_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIV, S_ROUND} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic [SIG_W:0]    rem_q, rem_d;
    logic [SIG_W-1:0]  div_q, div_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hold_q, hold_d;
    logic              ready_q, ready_d;
    logic              valid_out_q, valid_out_d;
    logic [W-1:0]      result_q, result_d;
    logic [4:0]        flags_q, flags_d;

    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  fa, fb;
    logic [SIG_W-1:0]  ma, mb;
    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              spec;
    logic [W-1:0]      sres, inf_w, zero_w;
    logic [4:0]        sflg;
    logic [XW-1:0]     e_raw, e_r;
    logic [SIG_W+1:0]  trial;
    logic [SIG_W:0]    mant_r;
    logic              g_bit, r_bit, st_bit, up, ovf, unf;

    always_comb begin
        ea     = a_q[W-2:MAN_W];
        eb     = b_q[W-2:MAN_W];
        fa     = a_q[MAN_W-1:0];
        fb     = b_q[MAN_W-1:0];
        ma     = {1'b1, fa};
        mb     = {1'b1, fb};
        sgn    = a_q[W-1] ^ b_q[W-1];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_zero = ~(|ea);        // subnormals flush to zero
        b_zero = ~(|eb);
        inf_w  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        zero_w = {sgn, {(W-1){1'b0}}};
        e_raw  = {2'b00, ea} - {2'b00, eb} + BIAS;   // two's complement
        spec   = 1'b1;
        sres   = '0;
        sflg   = '0;
        if (a_nan | b_nan) begin
            sres = QNAN;
            sflg = 5'b10000;
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            sres = QNAN;
            sflg = 5'b10000;
        end else if (b_zero & ~a_inf) begin
            sres = inf_w;
            sflg = 5'b01000;
        end else if (a_inf) begin
            sres = inf_w;
        end else if (a_zero | b_inf) begin
            sres = zero_w;
        end else begin
            spec = 1'b0;
        end

        trial  = {1'b0, rem_q} - {2'b00, div_q};
        g_bit  = quo_q[1];
        r_bit  = quo_q[0];
        st_bit = |rem_q;
        up     = g_bit & (r_bit | st_bit | quo_q[2]);
        mant_r = {1'b0, quo_q[QW-1:2]} + {{SIG_W{1'b0}}, up};
        e_r    = exp_q + {{(XW-1){1'b0}}, mant_r[SIG_W]};
        ovf    = ~e_r[XW-1] & (e_r >= EMAX);
        unf    = e_r[XW-1] | (e_r == '0);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        exp_d       = exp_q;
        rem_d       = rem_q;
        div_d       = div_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        ready_d     = ready_q;
        valid_out_d = 1'b0;
        result_d    = result_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    a_d     = a;
                    b_d     = b;
                    hold_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (spec) begin
                    // specials dwell one extra cycle for a fixed two-cycle latency
                    hold_d = 1'b1;
                    if (hold_q) begin
                        result_d    = sres;
                        flags_d     = FLAGS_EN ? sflg : 5'b0;
                        valid_out_d = 1'b1;
                        ready_d     = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else begin
                    if (ma < mb) begin
                        rem_d = {ma, 1'b0};
                        exp_d = e_raw - XW'(1);
                    end else begin
                        rem_d = {1'b0, ma};
                        exp_d = e_raw;
                    end
                    div_d   = mb;
                    quo_d   = '0;
                    cnt_d   = CW'(QW - 1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (!trial[SIG_W+1]) rem_d = {trial[SIG_W-1:0], 1'b0};
                else                 rem_d = {rem_q[SIG_W-1:0], 1'b0};
                quo_d = {quo_q[QW-2:0], ~trial[SIG_W+1]};
                if (cnt_q == '0) state_d = S_ROUND;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_ROUND: begin
                if (ovf) begin
                    result_d = inf_w;
                    flags_d  = FLAGS_EN ? 5'b00101 : 5'b0;
                end else if (unf) begin
                    result_d = zero_w;
                    flags_d  = FLAGS_EN ? 5'b00011 : 5'b0;
                end else begin
                    result_d = {sgn, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
                    flags_d  = FLAGS_EN ? {4'b0000, g_bit | r_bit | st_bit} : 5'b0;
                end
                valid_out_d = 1'b1;
                ready_d     = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            exp_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            ready_q     <= 1'b1;
            valid_out_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            exp_q       <= exp_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            valid_out_q <= valid_out_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign ready     = ready_q;
    assign valid_out = valid_out_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule
